// File: rtl/sys_pll_ctrl_pkg.sv
// sys_pll_ctrl_pkg
//   Shared types and constants for the system PLL reset/lock controller.
//   - pll_state_e : FSM state encoding, also exported on state_dbg.
//   - RELOCK_W    : width of the loss-of-lock event counter.
//   - DEF_*       : default cycle counts for a 50 MHz reference clock.
//   - relock_inc  : saturating increment for the loss-of-lock counter.
package sys_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RUN       = 3'd2,
    FAIL      = 3'd3
  } pll_state_e;

  localparam int RELOCK_W             = 8;
  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_RETRY_MAX        = 4;
  localparam int DEF_CNT_W            = 16;

  function automatic logic [RELOCK_W-1:0] relock_inc(input logic [RELOCK_W-1:0] v);
    return (&v) ? v : v + RELOCK_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Generic 1-bit two-flop synchronizer into the clk domain.
//   Ports: clk (clock), rst (sync active-high, clears both flops),
//          d (asynchronous input), q (synchronized output, 2-cycle latency).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  assign meta_d = d;
  assign sync_d = meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sys_pll_rst_ctrl.sv
// sys_pll_rst_ctrl
//   Reset sequencer and lock supervisor for the system PLL, clocked by refclk.
//   Pulses the PLL reset, waits for a stable lock, then releases sys_rst.
//   Loss of lock or a software request re-sequences the PLL; repeated lock
//   timeouts park the block in FAIL until rst or soft_rst_req.
//   Ports:
//     refclk        sole clock
//     rst           synchronous active-high reset
//     locked        PLL lock (asynchronous, synchronized here)
//     soft_rst_req  single-cycle request to re-sequence the PLL
//     pll_rst       PLL reset (registered)
//     sys_rst       system reset, active-high (registered)
//     pll_ready     high only in RUN (registered)
//     fail          high only in FAIL (registered)
//     relock_cnt    saturating count of loss-of-lock events since rst
//     state_dbg     current state encoding
module sys_pll_rst_ctrl
  import sys_pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int RETRY_MAX        = DEF_RETRY_MAX,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                locked,
  input  logic                soft_rst_req,
  output logic                pll_rst,
  output logic                sys_rst,
  output logic                pll_ready,
  output logic                fail,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic [2:0]          state_dbg
);

  localparam int RTRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  localparam logic [CNT_W-1:0]  PULSE_LAST  = CNT_W'(RST_PULSE_CYC);
  localparam logic [CNT_W-1:0]  TOUT_LAST   = CNT_W'(LOCK_TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(LOCK_STABLE_CYC);
  localparam logic [RTRY_W-1:0] RETRY_LAST  = RTRY_W'(RETRY_MAX);

  logic locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  pll_state_e          state_q, state_d;
  logic [CNT_W-1:0]    pulse_q, pulse_d;
  logic [CNT_W-1:0]    tout_q, tout_d;
  logic [CNT_W-1:0]    stable_q, stable_d;
  logic [RTRY_W-1:0]   retry_q, retry_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic pll_rst_q, pll_rst_d;
  logic sys_rst_q, sys_rst_d;
  logic ready_q, ready_d;
  logic fail_q, fail_d;

  always_comb begin
    state_d  = state_q;
    pulse_d  = pulse_q;
    tout_d   = tout_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    relock_d = relock_q;

    unique case (state_q)
      PLL_RST: begin
        if (soft_rst_req) begin
          pulse_d = '0;
          retry_d = '0;
        end else begin
          pulse_d = pulse_q + CNT_W'(1);
          if (pulse_d == PULSE_LAST) begin
            state_d  = WAIT_LOCK;
            tout_d   = '0;
            stable_d = '0;
          end
        end
      end

      WAIT_LOCK: begin
        if (soft_rst_req) begin
          state_d = PLL_RST;
          pulse_d = '0;
          retry_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          // Release is decided on the registered count, which is what puts
          // one cycle between the last qualifying sample and sys_rst falling.
          state_d = RUN;
          retry_d = '0;
        end else begin
          tout_d   = tout_q + CNT_W'(1);
          stable_d = locked_s ? stable_q + CNT_W'(1) : '0;
          // A lock that qualifies on the very timeout cycle is allowed to
          // release on the next cycle rather than being thrown away.
          if (tout_d == TOUT_LAST && stable_d != STABLE_LAST) begin
            retry_d = retry_q + RTRY_W'(1);
            if (retry_d == RETRY_LAST) begin
              state_d = FAIL;
            end else begin
              state_d = PLL_RST;
              pulse_d = '0;
            end
          end
        end
      end

      RUN: begin
        if (!locked_s) begin
          state_d  = PLL_RST;
          pulse_d  = '0;
          relock_d = relock_inc(relock_q);
        end else if (soft_rst_req) begin
          state_d = PLL_RST;
          pulse_d = '0;
        end
      end

      FAIL: begin
        if (soft_rst_req) begin
          state_d = PLL_RST;
          pulse_d = '0;
          retry_d = '0;
        end
      end

      default: begin
        state_d = PLL_RST;
        pulse_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    pll_rst_d = (state_d == PLL_RST) || (state_d == FAIL);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fail_d    = (state_d == FAIL);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= PLL_RST;
      pulse_q   <= '0;
      tout_q    <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      tout_q    <= tout_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst    = sys_rst_q;
  assign pll_ready  = ready_q;
  assign fail       = fail_q;
  assign relock_cnt = relock_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sys_pll_rst_ctrl.sv
// tb_sys_pll_rst_ctrl
//   Directed sequence with randomized delays for sys_pll_rst_ctrl. Expected
//   latencies come from the behavioural rules (pulse length, sync delay plus
//   stable window plus output register, timeout length) and an integer model
//   of the saturating loss-of-lock count.
module tb_sys_pll_rst_ctrl;

  localparam int PULSE   = 4;
  localparam int TOUT    = 100;
  localparam int STABLE  = 8;
  localparam int RETRIES = 2;

  localparam int REL_LAT  = 2 + STABLE + 1;          // locked rise -> release
  localparam int FAIL_LAT = RETRIES * (PULSE + TOUT); // PLL_RST entry -> FAIL

  localparam int S_RST  = 0;
  localparam int S_WAIT = 1;
  localparam int S_RUN  = 2;
  localparam int S_FAIL = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       pll_rst, sys_rst, pll_ready, fail;
  logic [7:0] relock_cnt;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int exp_relock = 0;

  always #10 refclk = ~refclk;

  sys_pll_rst_ctrl #(
    .RST_PULSE_CYC    (PULSE),
    .LOCK_TIMEOUT_CYC (TOUT),
    .LOCK_STABLE_CYC  (STABLE),
    .RETRY_MAX        (RETRIES),
    .CNT_W            (16)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .pll_ready    (pll_ready),
    .fail         (fail),
    .relock_cnt   (relock_cnt),
    .state_dbg    (state_dbg)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Ticks until the selected output (0 pll_rst, 1 sys_rst, 2 fail) equals lvl.
  task automatic wait_for(input int sel, input logic lvl, input int bound, output int n);
    logic v;
    n = 0;
    do begin
      tick();
      n++;
      case (sel)
        0:       v = pll_rst;
        1:       v = sys_rst;
        default: v = fail;
      endcase
    end while (v !== lvl && n < bound);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
    chk({tag, "_ready"},   32'(pll_ready), 0);
    chk({tag, "_fail"},    32'(fail), 0);
    chk({tag, "_relock"},  32'(relock_cnt), 0);
    chk({tag, "_state"},   32'(state_dbg), S_RST);
  endtask

  task automatic do_reset(input string tag);
    int n;
    rst = 1'b1;
    soft_rst_req = 1'b0;
    tick();
    rst = 1'b0;
    exp_relock = 0;
    check_reset_vals(tag);
    wait_for(0, 1'b0, 20, n);
    chk({tag, "_pulse"}, 32'(n), PULSE);
    chk({tag, "_wait"}, 32'(state_dbg), S_WAIT);
  endtask

  // Called in WAIT_LOCK with locked low.
  task automatic bring_up(input int dly, input string tag);
    int n;
    repeat (dly) tick();
    locked = 1'b1;
    wait_for(1, 1'b0, 40, n);
    chk({tag, "_rel_lat"}, 32'(n), REL_LAT);
    chk({tag, "_ready"}, 32'(pll_ready), 1);
    chk({tag, "_state"}, 32'(state_dbg), S_RUN);
  endtask

  // Called in RUN; drops locked and optionally aligns a soft request with
  // the cycle the synchronized loss reaches the controller.
  task automatic lose_lock(input logic with_soft, input string tag);
    locked = 1'b0;
    tick();
    tick();
    chk({tag, "_still_run"}, 32'(sys_rst), 0);
    if (with_soft) soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
    chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_ready"}, 32'(pll_ready), 0);
    chk({tag, "_relock"}, 32'(relock_cnt), 32'(exp_relock));
  endtask

  initial begin
    int n, d, h;

    // Reset and normal bring-up, lock 20 cycles after rst release.
    do_reset("rst0");
    bring_up(PULSE == 4 ? 16 : 16, "boot");
    chk("boot_relock", 32'(relock_cnt), 0);

    // Loss of lock in RUN and relock.
    lose_lock(1'b0, "loss1");
    wait_for(0, 1'b0, 20, n);
    chk("loss1_pulse", 32'(n), PULSE);
    bring_up($urandom_range(0, 40), "loss1_up");

    // Glitchy lock: stable window restarts after a one-cycle drop.
    lose_lock(1'b0, "loss2");
    wait_for(0, 1'b0, 20, n);
    d = $urandom_range(0, 40);
    h = $urandom_range(1, STABLE - 1);
    repeat (d) tick();
    locked = 1'b1;
    repeat (h) tick();
    locked = 1'b0;
    tick();
    chk("glitch_no_early", 32'(sys_rst), 1);
    locked = 1'b1;
    wait_for(1, 1'b0, 40, n);
    chk("glitch_rel_lat", 32'(n), REL_LAT);

    // Soft request alone in RUN: no relock change; lock already present,
    // so release follows the stable window plus the output register.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("soft_pll_rst", 32'(pll_rst), 1);
    chk("soft_relock", 32'(relock_cnt), 32'(exp_relock));
    wait_for(0, 1'b0, 20, n);
    chk("soft_pulse", 32'(n), PULSE);
    wait_for(1, 1'b0, 40, n);
    chk("soft_rel_lat", 32'(n), STABLE + 1);

    // Soft request coincident with lock loss: one entry, one increment.
    lose_lock(1'b1, "coinc");
    wait_for(0, 1'b0, 20, n);
    chk("coinc_pulse", 32'(n), PULSE);
    bring_up($urandom_range(0, 20), "coinc_up");

    // Repeated loss of lock until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      lose_lock(1'b0, "rep");
      wait_for(0, 1'b0, 20, n);
      bring_up($urandom_range(0, 3), "rep_up");
    end
    chk("relock_sat", 32'(relock_cnt), 255);

    // Reset at timeout count 50 in WAIT_LOCK.
    lose_lock(1'b0, "pre_rst");
    wait_for(0, 1'b0, 20, n);
    repeat (50) tick();
    do_reset("midrst");
    bring_up($urandom_range(0, 40), "midrst_up");

    // Timeout path to FAIL with locked held low.
    locked = 1'b0;
    do_reset("rst1");
    wait_for(0, 1'b1, 200, n);
    chk("to1_len", 32'(n), TOUT);
    chk("to1_state", 32'(state_dbg), S_RST);
    wait_for(0, 1'b0, 20, n);
    chk("to2_pulse", 32'(n), PULSE);
    wait_for(0, 1'b1, 200, n);
    chk("to2_len", 32'(n), TOUT);
    chk("fail_flag", 32'(fail), 1);
    chk("fail_pll_rst", 32'(pll_rst), 1);
    chk("fail_sys_rst", 32'(sys_rst), 1);
    chk("fail_state", 32'(state_dbg), S_FAIL);

    // Lock is ignored while failed.
    locked = 1'b1;
    repeat ($urandom_range(5, 30)) tick();
    chk("fail_hold", 32'(state_dbg), S_FAIL);
    locked = 1'b0;
    repeat (3) tick();

    // Soft request out of FAIL clears the retries: two full timeouts again.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("fexit_state", 32'(state_dbg), S_RST);
    chk("fexit_fail", 32'(fail), 0);
    chk("fexit_pll_rst", 32'(pll_rst), 1);
    wait_for(2, 1'b1, 400, n);
    chk("fexit_refail", 32'(n), FAIL_LAT);

    // Soft request in WAIT_LOCK after one timeout also clears the retries.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    wait_for(0, 1'b0, 20, n);
    chk("w_pulse", 32'(n), PULSE);
    wait_for(0, 1'b1, 200, n);
    chk("w_to_len", 32'(n), TOUT);
    chk("w_to_state", 32'(state_dbg), S_RST);
    wait_for(0, 1'b0, 20, n);
    repeat ($urandom_range(5, 90)) tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("wsoft_state", 32'(state_dbg), S_RST);
    wait_for(2, 1'b1, 400, n);
    chk("wsoft_refail", 32'(n), FAIL_LAT);

    // Recovery from FAIL to a normal bring-up.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    wait_for(0, 1'b0, 20, n);
    chk("rec_pulse", 32'(n), PULSE);
    bring_up($urandom_range(0, 60), "rec_up");
    chk("rec_relock", 32'(relock_cnt), 32'(exp_relock));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
